// File: rtl/dart_bram_fifo_ctrl.sv
// dart_bram_fifo_ctrl
// Wraps a dual-port block RAM (registered read address, one-cycle read
// latency) into a show-ahead valid/ready FIFO. A two-entry prefetch buffer
// (head + skid) hides the RAM latency so the output sustains one word/cycle.
//
// Ports:
//   clock, reset        sole clock; synchronous active-high reset
//   in_valid/in_data    upstream word offered
//   in_ready            FIFO accepts a word this cycle
//   out_valid/out_data  show-ahead head word
//   out_ready           downstream consumes the head this cycle
//   count               words held: RAM + in-flight read + prefetch
//   ram_enable          RAM enable (low while reset is asserted)
//   ram_wen/ram_waddr   RAM write strobe / address
//   ram_din             RAM write data (= in_data)
//   ram_raddr           RAM read address
//   ram_dout            RAM read data, valid one cycle after issue
module dart_bram_fifo_ctrl #(
  parameter int unsigned WIDTH   = 36,
  parameter int unsigned LOG_DEP = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [LOG_DEP+1:0] count,
  output logic               ram_enable,
  output logic               ram_wen,
  output logic [LOG_DEP-1:0] ram_waddr,
  output logic [LOG_DEP-1:0] ram_raddr,
  output logic [WIDTH-1:0]   ram_din,
  input  logic [WIDTH-1:0]   ram_dout
);

  localparam int unsigned DEPTH = 1 << LOG_DEP;
  localparam int unsigned PW    = LOG_DEP + 1;
  localparam int unsigned CW    = LOG_DEP + 2;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [1:0]       r_pf_cnt;
  logic             r_rd_pend;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;

  logic [PW-1:0]    w_ram_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_rd_issue;
  logic [1:0]       w_pf_after_pop;
  logic [2:0]       w_pf_load;

  // Occupancy of the RAM itself; the pointer MSB disambiguates full/empty.
  assign w_ram_count = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_ram_count == PW'(DEPTH));

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready = ~reset & ~w_full;
  assign w_push   = in_valid & in_ready;

  assign out_valid = (r_pf_cnt != 2'd0);
  assign out_data  = r_head;
  assign w_pop     = out_valid & out_ready;

  // Prefetch slots committed once this cycle's pop and arriving read land.
  assign w_pf_after_pop = r_pf_cnt - 2'(w_pop);
  assign w_pf_load      = 3'(w_pf_after_pop) + 3'(r_rd_pend);

  // Only issue a read when its data is guaranteed a free slot next cycle.
  assign w_rd_issue = (w_ram_count != '0) & (w_pf_load < 3'd2);

  assign count = CW'(w_ram_count) + CW'(r_rd_pend) + CW'(r_pf_cnt);

  assign ram_enable = ~reset;
  assign ram_wen    = w_push;
  assign ram_waddr  = r_wr_ptr[LOG_DEP-1:0];
  assign ram_raddr  = r_rd_ptr[LOG_DEP-1:0];
  assign ram_din    = in_data;

  // Pointer and prefetch bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pf_cnt  <= 2'd0;
      r_rd_pend <= 1'b0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_rd_pend <= w_rd_issue;
      r_pf_cnt  <= w_pf_load[1:0];
    end
  end

  // Prefetch data: skid shifts to head on pop, then the arriving RAM word
  // fills the first slot left free after that shift.
  always_ff @(posedge clock) begin
    if (w_pop) r_head <= r_skid;
    if (r_rd_pend) begin
      if (w_pf_after_pop == 2'd0) r_head <= ram_dout;
      else                        r_skid <= ram_dout;
    end
  end

endmodule

// File: tb/tb_dart_bram_fifo_ctrl.sv
// Directed bench for dart_bram_fifo_ctrl with a behavioural block RAM
// (registered read, read-first) and a queue scoreboard for random traffic.
module tb_dart_bram_fifo_ctrl;

  localparam int unsigned WIDTH   = 36;
  localparam int unsigned LOG_DEP = 2;
  localparam int unsigned DEPTH   = 1 << LOG_DEP;
  localparam int unsigned CW      = LOG_DEP + 2;
  localparam int          NWORDS  = 10000;
  localparam int          BUDGET  = 60000;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_ready;
  logic [CW-1:0]      count;
  logic               ram_enable;
  logic               ram_wen;
  logic [LOG_DEP-1:0] ram_waddr;
  logic [LOG_DEP-1:0] ram_raddr;
  logic [WIDTH-1:0]   ram_din;
  logic [WIDTH-1:0]   ram_dout;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   sb [$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  dart_bram_fifo_ctrl #(.WIDTH(WIDTH), .LOG_DEP(LOG_DEP)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .ram_enable (ram_enable),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_raddr  (ram_raddr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Dual-port RAM: registered read address, one-cycle latency.
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_wen) mem[ram_waddr] <= ram_din;
      ram_dout <= mem[ram_raddr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    int exp_v;
    int got;
    int sent;
    int cyc;
    logic [WIDTH-1:0] w;

    // Reset: a push offered during reset must not be accepted.
    reset = 1'b1; in_valid = 1'b1; in_data = WIDTH'(36'h77); out_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_in_ready",   64'(in_ready),   64'd0);
    chk("rst_ram_enable", 64'(ram_enable), 64'd0);
    chk("rst_ram_wen",    64'(ram_wen),    64'd0);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_count",      64'(count),      64'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    #1;
    chk("post_rst_in_ready",   64'(in_ready),   64'd1);
    chk("post_rst_ram_enable", 64'(ram_enable), 64'd1);
    chk("post_rst_count",      64'(count),      64'd0);

    // Single word: push at cycle 0, visible at cycle 3.
    in_valid = 1'b1; in_data = WIDTH'(36'hA5);
    #1;
    chk("single_wen",   64'(ram_wen),   64'd1);
    chk("single_waddr", 64'(ram_waddr), 64'd0);
    chk("single_din",   64'(ram_din),   64'hA5);
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_c1_count", 64'(count),     64'd1);
    chk("single_c1_valid", 64'(out_valid), 64'd0);
    chk("single_c1_raddr", 64'(ram_raddr), 64'd0);
    tick();
    #1;
    chk("single_c2_count", 64'(count),     64'd1);
    chk("single_c2_valid", 64'(out_valid), 64'd0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("single_c3_valid", 64'(out_valid), 64'd1);
    chk("single_c3_data",  64'(out_data),  64'hA5);
    chk("single_c3_count", 64'(count),     64'd1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("single_c4_count", 64'(count),     64'd0);
    chk("single_c4_valid", 64'(out_valid), 64'd0);
    tick();

    // Fill with downstream stalled: capacity is DEPTH + 2.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      #1;
      chk("fill_in_ready", 64'(in_ready), (i < 6) ? 64'd1 : 64'd0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("fill_accepted", 64'(acc),      64'd6);
    chk("fill_count",    64'(count),    64'd6);
    chk("fill_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    exp_v = 0;
    for (int c = 0; c < 20 && exp_v < 6; c++) begin
      #1;
      if (out_valid) begin
        chk("fill_drain_data", 64'(out_data), 64'(exp_v));
        exp_v++;
      end
      tick();
    end
    chk("fill_drain_words", 64'(exp_v), 64'd6);
    #1;
    chk("fill_drain_count", 64'(count),     64'd0);
    chk("fill_drain_valid", 64'(out_valid), 64'd0);
    tick();

    // Streaming at full rate: one word per cycle after 3-cycle latency.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = WIDTH'(32'h100 + 32'(i));
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_count",    64'(count),    (i < 3) ? 64'(i) : 64'd3);
      if (i >= 3) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data",  64'(out_data),  64'(32'h100 + 32'(i - 3)));
      end else begin
        chk("stream_valid_lat", 64'(out_valid), 64'd0);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 100; i < 103; i++) begin
      #1;
      chk("stream_tail_valid", 64'(out_valid), 64'd1);
      chk("stream_tail_data",  64'(out_data),  64'(32'h100 + 32'(i - 3)));
      tick();
    end
    #1;
    chk("stream_end_valid", 64'(out_valid), 64'd0);
    chk("stream_end_count", 64'(count),     64'd0);
    tick();

    // Random valid/ready against a queue scoreboard.
    got = 0; sent = 0; cyc = 0;
    while (got < NWORDS && cyc < BUDGET) begin
      in_valid  = (sent < NWORDS) && ($urandom_range(0, 1) == 1);
      in_data   = WIDTH'({$urandom(), $urandom()});
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      chk("rand_count",     64'(count), 64'(sb.size()));
      chk("rand_count_max", 64'(count <= CW'(DEPTH + 2)), 64'd1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rand_underflow", 64'd1, 64'd0);
        end else begin
          w = sb.pop_front();
          chk("rand_data", 64'(out_data), 64'(w));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        sent++;
      end
      tick();
      cyc++;
    end
    chk("rand_words_done", 64'(got), 64'(NWORDS));
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rand_end_count", 64'(count), 64'd0);
    sb.delete();
    tick();

    // Pointer wrap with DEPTH-1 words held while pushing and popping.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(32'h200 + 32'(i));
      #1;
      chk("wrap_prefill_ready", 64'(in_ready), 64'd1);
      sb.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("wrap_prefill_count", 64'(count), 64'd3);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = WIDTH'(32'h300 + 32'(i));
      #1;
      chk("wrap_in_ready", 64'(in_ready),  64'd1);
      chk("wrap_valid",    64'(out_valid), 64'd1);
      chk("wrap_count",    64'(count),     64'd3);
      w = sb.pop_front();
      chk("wrap_data", 64'(out_data), 64'(w));
      sb.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        w = sb.pop_front();
        chk("wrap_drain_data", 64'(out_data), 64'(w));
      end
      tick();
    end
    chk("wrap_drained", 64'(sb.size()), 64'd0);
    #1;
    chk("wrap_end_count", 64'(count), 64'd0);
    out_ready = 1'b0;
    tick();

    // Reset mid-stream with a read in flight.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(32'h400 + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    #1;
    chk("mid_prefill_count", 64'(count), 64'd5);
    out_ready = 1'b1;
    #1;
    chk("mid_pop_data", 64'(out_data), 64'h400);
    tick();
    reset = 1'b1; in_valid = 1'b1; in_data = WIDTH'(36'h77); out_ready = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_wen",      64'(ram_wen),  64'd0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_post_valid", 64'(out_valid), 64'd0);
    chk("mid_post_count", 64'(count),     64'd0);
    in_valid = 1'b1; in_data = WIDTH'(36'h3C);
    #1;
    chk("mid_push_wen", 64'(ram_wen), 64'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (k == 3) begin
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        chk("mid_out_data",  64'(out_data),  64'h3C);
      end else begin
        chk("mid_out_idle", 64'(out_valid), 64'd0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
